multi_axis_integrator: RTL and testbench

//  Parametrised double integrator (acceleration -> velocity -> position) for
//  CH axes of signed fixed-point IMU data. One shared multiplier is

---
 rtl/multi_axis_integrator.sv | 130 +++++++++++++
 tb/tb_multi_axis_integrator.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/multi_axis_integrator.sv
// Double integrator (acceleration -> velocity -> position) for CH signed axes.
// One shared multiplier is time-multiplexed across axes and phases by a small FSM.
module multi_axis_integrator #(
  parameter int unsigned W    = 16,
  parameter int unsigned FRAC = 8,
  parameter int unsigned CH   = 3,
  parameter int unsigned SAT  = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enable,
  input  logic            clear,
  input  logic [CH*W-1:0] acc_in,
  input  logic [W-1:0]    dt,
  output logic [CH*W-1:0] vel_out,
  output logic [CH*W-1:0] pos_out,
  output logic            bussy,
  output logic            done
);

  localparam int unsigned CW = (CH > 1) ? $clog2(CH) : 1;
  localparam logic [CW-1:0] LastCh = CW'(CH - 1);

  localparam logic [1:0] s_idle = 2'd0;
  localparam logic [1:0] s_vel  = 2'd1;
  localparam logic [1:0] s_pos  = 2'd2;
  localparam logic [1:0] s_done = 2'd3;

  logic [1:0]    state_q;
  logic [CW-1:0] ch_q;
  logic [W-1:0]  dt_q;
  logic [W-1:0]  a_q [CH];
  logic [W-1:0]  v_q [CH];
  logic [W-1:0]  p_q [CH];

  logic [W-1:0]          mul_op;
  logic [W-1:0]          add_op;
  logic signed [2*W-1:0] prod;
  logic signed [2*W-1:0] prod_sh;
  logic [2*W:0]          sum;
  logic [W-1:0]          res;

  // Clamp (SAT!=0) or wrap a 2W+1 bit sum into the signed W-bit range.
  function automatic logic [W-1:0] fit(input logic [2*W:0] s);
    logic ovf;
    ovf = (s[2*W:W-1] != '0) && (s[2*W:W-1] != '1);
    if ((SAT != 0) && ovf) begin
      fit = s[2*W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end else begin
      fit = s[W-1:0];
    end
  endfunction

  // VEL multiplies the latched acceleration; POS multiplies the fresh velocity.
  always_comb begin
    mul_op  = (state_q == s_vel) ? a_q[ch_q] : v_q[ch_q];
    add_op  = (state_q == s_vel) ? v_q[ch_q] : p_q[ch_q];
    prod    = $signed({{W{mul_op[W-1]}}, mul_op}) * $signed({{W{dt_q[W-1]}}, dt_q});
    prod_sh = prod >>> FRAC;
    sum     = {prod_sh[2*W-1], prod_sh} + {{(W+1){add_op[W-1]}}, add_op};
    res     = fit(sum);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= s_idle;
      ch_q    <= '0;
      dt_q    <= '0;
      vel_out <= '0;
      pos_out <= '0;
      for (int i = 0; i < CH; i++) begin
        a_q[i] <= '0;
        v_q[i] <= '0;
        p_q[i] <= '0;
      end
    end else begin
      case (state_q)
        s_idle: begin
          if (clear) begin
            ch_q    <= '0;
            dt_q    <= '0;
            vel_out <= '0;
            pos_out <= '0;
            for (int i = 0; i < CH; i++) begin
              a_q[i] <= '0;
              v_q[i] <= '0;
              p_q[i] <= '0;
            end
          end else if (enable) begin
            dt_q    <= dt;
            ch_q    <= '0;
            state_q <= s_vel;
            for (int i = 0; i < CH; i++) begin
              a_q[i] <= acc_in[i*W +: W];
            end
          end
        end
        s_vel: begin
          v_q[ch_q] <= res;
          state_q   <= s_pos;
        end
        s_pos: begin
          p_q[ch_q] <= res;
          if (ch_q == LastCh) begin
            state_q <= s_done;
            // Outputs load on entry to DONE so they are valid while done is high;
            // the last axis position bypasses its register.
            for (int i = 0; i < CH; i++) begin
              vel_out[i*W +: W] <= v_q[i];
              pos_out[i*W +: W] <= (CW'(i) == LastCh) ? res : p_q[i];
            end
          end else begin
            ch_q    <= ch_q + CW'(1);
            state_q <= s_vel;
          end
        end
        s_done: begin
          state_q <= s_idle;
        end
        default: begin
          state_q <= s_idle;
        end
      endcase
    end
  end

  assign bussy = (state_q != s_idle);
  assign done  = (state_q == s_done);

endmodule

// File: tb/tb_multi_axis_integrator.sv
// Randomised bench for multi_axis_integrator; a saturating and a wrapping instance
// share stimulus and are checked against an arithmetic reference model.
module tb_multi_axis_integrator;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        clear;
  logic [47:0] acc_in;
  logic [15:0] dt;
  logic [47:0] vel_s, pos_s, vel_w, pos_w;
  logic        bussy_s, done_s, bussy_w, done_w;

  int n_checks = 0;
  int n_errors = 0;

  longint sv[3], sp[3], wv[3], wp[3];

  always #5 clk = ~clk;

  multi_axis_integrator #(.W(16), .FRAC(8), .CH(3), .SAT(1)) u_sat (
    .clk(clk), .rst(rst), .enable(enable), .clear(clear), .acc_in(acc_in), .dt(dt),
    .vel_out(vel_s), .pos_out(pos_s), .bussy(bussy_s), .done(done_s)
  );

  multi_axis_integrator #(.W(16), .FRAC(8), .CH(3), .SAT(0)) u_wrap (
    .clk(clk), .rst(rst), .enable(enable), .clear(clear), .acc_in(acc_in), .dt(dt),
    .vel_out(vel_w), .pos_out(pos_w), .bussy(bussy_w), .done(done_w)
  );

  task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic longint fitm(input longint s, input bit sat);
    longint r;
    if (sat) begin
      if (s > 32767) return 32767;
      if (s < -32768) return -32768;
      return s;
    end
    r = s % 65536;
    if (r < 0) r += 65536;
    if (r >= 32768) r -= 65536;
    return r;
  endfunction

  // acc + floor(x*d / 256), then fitted
  function automatic longint step(input longint acc, input longint x, input longint d,
                                  input bit sat);
    longint pr, q;
    pr = x * d;
    q  = pr / 256;
    if ((pr % 256 != 0) && (pr < 0)) q -= 1;
    return fitm(acc + q, sat);
  endfunction

  task automatic model_zero();
    for (int i = 0; i < 3; i++) begin
      sv[i] = 0; sp[i] = 0; wv[i] = 0; wp[i] = 0;
    end
  endtask

  task automatic model_run(input logic [47:0] a, input logic [15:0] d);
    longint ai, dd;
    dd = longint'($signed(d));
    for (int i = 0; i < 3; i++) begin
      ai = longint'($signed(a[i*16 +: 16]));
      sv[i] = step(sv[i], ai, dd, 1'b1);
      sp[i] = step(sp[i], sv[i], dd, 1'b1);
      wv[i] = step(wv[i], ai, dd, 1'b0);
      wp[i] = step(wp[i], wv[i], dd, 1'b0);
    end
  endtask

  function automatic logic [47:0] exp_vec(input int which);
    logic [47:0] r;
    r = '0;
    for (int i = 0; i < 3; i++) begin
      case (which)
        0:       r[i*16 +: 16] = 16'(sv[i]);
        1:       r[i*16 +: 16] = 16'(sp[i]);
        2:       r[i*16 +: 16] = 16'(wv[i]);
        default: r[i*16 +: 16] = 16'(wp[i]);
      endcase
    end
    return r;
  endfunction

  task automatic check_outs(input string tag);
    check({tag, "_vel_sat"}, vel_s, exp_vec(0));
    check({tag, "_pos_sat"}, pos_s, exp_vec(1));
    check({tag, "_vel_wrap"}, vel_w, exp_vec(2));
    check({tag, "_pos_wrap"}, pos_w, exp_vec(3));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    model_zero();
    check_outs("clr");
    check("clr_bussy", 48'(bussy_s), 48'd0);
  endtask

  // One run: enable for a cycle, then watch bussy/done for 12 cycles.
  task automatic do_run(input logic [15:0] ax, input logic [15:0] ay, input logic [15:0] az,
                        input logic [15:0] d, input bit pulse, input string tag);
    logic [47:0] old_vs, old_ps;
    int busy_cnt, done_k;
    old_vs = exp_vec(0);
    old_ps = exp_vec(1);
    acc_in = {az, ay, ax};
    dt     = d;
    enable = 1'b1;
    tick();
    enable = 1'b0;
    acc_in = {16'($urandom), 16'($urandom), 16'($urandom)};
    dt     = 16'($urandom);
    model_run({az, ay, ax}, d);
    busy_cnt = 0;
    done_k   = 0;
    for (int k = 1; k <= 12; k++) begin
      if (bussy_s) busy_cnt++;
      if (done_s && done_k == 0) begin
        done_k = k;
        check_outs(tag);
      end
      if (k == 6) begin
        check({tag, "_hold_vel"}, vel_s, old_vs);
        check({tag, "_hold_pos"}, pos_s, old_ps);
      end
      enable = pulse && (k == 2);
      clear  = pulse && (k == 3);
      tick();
    end
    enable = 1'b0;
    clear  = 1'b0;
    check({tag, "_busy_cycles"}, 48'(busy_cnt), 48'd7);
    check({tag, "_done_cycle"}, 48'(done_k), 48'd7);
  endtask

  initial begin
    int done_cnt;
    logic [15:0] rx, ry, rz, rd;
    rst = 1'b1; enable = 1'b0; clear = 1'b0; acc_in = '0; dt = '0;
    model_zero();
    repeat (10) tick();
    check("rst_vel", vel_s, 48'd0);
    check("rst_pos", pos_s, 48'd0);
    check("rst_bussy", 48'(bussy_s), 48'd0);
    check("rst_done", 48'(done_s), 48'd0);
    rst = 1'b0;
    tick();

    do_run(16'h0000, 16'h0000, 16'h0000, 16'h0100, 1'b0, "t1");

    do_run(16'h00AA, 16'h0000, 16'h0000, 16'h0100, 1'b0, "t2a");
    check("t2a_xvel", 48'(vel_s[15:0]), 48'h00AA);
    check("t2a_xpos", 48'(pos_s[15:0]), 48'h00AA);
    do_run(16'h00AA, 16'h0000, 16'h0000, 16'h0100, 1'b0, "t2b");
    check("t2b_xvel", 48'(vel_s[15:0]), 48'h0154);
    check("t2b_xpos", 48'(pos_s[15:0]), 48'h01FE);

    do_clear();
    do_run(16'h0000, 16'hFF00, 16'h0000, 16'h0080, 1'b0, "t3y");
    check("t3_yvel", 48'(vel_s[31:16]), 48'hFF80);
    check("t3_ypos", 48'(pos_s[31:16]), 48'hFFC0);
    do_clear();
    do_run(16'h0000, 16'h0000, 16'hFFFF, 16'h0001, 1'b0, "t3z");
    check("t3_zvel", 48'(vel_s[47:32]), 48'hFFFF);
    check("t3_zpos", 48'(pos_s[47:32]), 48'hFFFF);

    do_clear();
    do_run(16'h7FFF, 16'h0000, 16'h0000, 16'h7FFF, 1'b0, "t4");
    check("t4_xvel_sat", 48'(vel_s[15:0]), 48'h7FFF);
    check("t4_xvel_wrap", 48'(vel_w[15:0]), 48'hFF00);

    // enable and clear pulsed mid-run must both be ignored
    do_run(16'h0123, 16'hFE00, 16'h0040, 16'h0180, 1'b1, "t5");
    tick();
    check("t5_idle", 48'(bussy_s), 48'd0);
    check_outs("t5_after");
    do_clear();

    // reset during POS of axis 1
    acc_in = 48'h0100_0200_0300;
    dt     = 16'h0100;
    enable = 1'b1;
    tick();
    enable = 1'b0;
    repeat (3) tick();
    check("t6_busy_before", 48'(bussy_s), 48'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_zero();
    check("t6_bussy", 48'(bussy_s), 48'd0);
    check_outs("t6");
    done_cnt = 0;
    repeat (10) begin
      if (done_s || bussy_s) done_cnt++;
      tick();
    end
    check("t6_no_done", 48'(done_cnt), 48'd0);

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 7) == 0) do_clear();
      rx = 16'($urandom);
      ry = 16'($urandom);
      rz = ($urandom_range(0, 1) != 0) ? 16'($urandom_range(0, 511)) : 16'($urandom);
      case ($urandom_range(0, 3))
        0:       rd = 16'h0000;
        1:       rd = 16'($urandom);
        default: rd = 16'($urandom_range(0, 767)) - 16'd384;
      endcase
      do_run(rx, ry, rz, rd, 1'($urandom_range(0, 1)), "rnd");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
